gray_ptr_ctrl: RTL
==================

// Module: gray_ptr_ctrl
// PURPOSE
//  Parametrised async-FIFO pointer controller: successor to the registered binary->gray encoder.
//  Holds the local (ADDR_WIDTH+1)-bit binary pointer and its gray copy, updated in the same cycle.
//  Compares against the remote gray pointer to drive full (write side) or empty (read side).
//  One instance per FIFO side; the mode is chosen by parameter.
// PARAMETERS
//  ADDR_WIDTH     5  RAM address bits; depth = 2**ADDR_WIDTH; legal range >= 2
//  MODE           0  0 = write side (flag = full), 1 = read side (flag = empty)
//  ALMOST_MARGIN  4  almost-flag threshold in entries; used only with GRAY_PTR_LEVEL_EN
// PORTS
//  clk            in   1     side clock
//  rst_n          in   1     asynchronous active-low reset
//  inc            in   1     push (MODE 0) or pop (MODE 1) request
//  sync_gray_ptr  in   AW+1  remote gray pointer, already 2-FF synchronised into clk outside this block
//  accept         out  1     inc & ~flag (combinational); the pointer advances this cycle
//  addr           out  AW    ptr_bin[AW-1:0], RAM address
//  gray_ptr       out  AW+1  registered gray pointer, exported to the other domain
//  flag           out  1     registered full (MODE 0) or empty (MODE 1)
//  level          out  AW+1  occupancy as seen from this side (option)
//  almost         out  1     almost-full (MODE 0) or almost-empty (MODE 1) (option)
// BEHAVIOUR
//  Reset (async): ptr_bin=0, gray_ptr=0, flag=0 (MODE 0) or 1 (MODE 1), level=0, almost=0 (MODE 0) or 1 (MODE 1).
//  bin_nxt  = ptr_bin + accept, mod 2**(AW+1). gray_nxt = bin_nxt ^ (bin_nxt>>1).
//  Every clk: ptr_bin<=bin_nxt; gray_ptr<=gray_nxt. Gray and binary never skew (0-cycle lag).
//  MODE 0: flag <= (gray_nxt == {~sync_gray_ptr[AW:AW-1], sync_gray_ptr[AW-2:0]}).
//  MODE 1: flag <= (gray_nxt == sync_gray_ptr).
//  The flag is evaluated on next-state values, so it asserts in the same edge as the accept that fills or empties.
//  inc while flag=1: accept=0; pointer, gray_ptr and addr hold; no overflow or underflow is possible.
//  A remote pointer change with no local inc re-evaluates flag on the next edge (deassertion is pessimistic by design).
//  Wrap: ptr_bin rolls from 2**(AW+1)-1 to 0 and gray_ptr from {1,0..0} to 0; addr wraps every 2**AW accepts.
//  Reset mid-operation: all state returns to reset values immediately; the first accept is taken on the first edge after release.
// CONFIGURATION
//  GRAY_PTR_LEVEL_EN defined:
//   - rbin = gray2bin(sync_gray_ptr).
//   - level <= MODE 0 ? bin_nxt-rbin : rbin-bin_nxt (mod 2**(AW+1)), range 0..2**AW.
//   - almost <= MODE 0 ? level_nxt >= 2**AW-ALMOST_MARGIN : level_nxt <= ALMOST_MARGIN.
//  GRAY_PTR_LEVEL_EN undefined:
//   - ports remain; level tied 0, almost tied to its reset value.
//   - no gray2bin logic is built.
// STRUCTURE
//  gray_pkg:
//   - functions bin2gray(), gray2bin(), parametrised by width
//   - localparams MODE_WR=0, MODE_RD=1
//  Sub-module gray_to_bin: XOR-prefix decoder, instantiated only under GRAY_PTR_LEVEL_EN.
//  Rest of the design is flat: a pointer register, a gray register, a comparator and the flag register.
// TESTING
//  1 Reset, MODE 0, AW=5, sync=0:
//    - 32 consecutive inc -> accept on all 32; flag=1 after the 32nd edge; gray_ptr=6'b110000.
//  2 Full hold:
//    - inc held 3 more cycles -> accept=0; addr=0; gray_ptr unchanged.
//    - set sync=6'b000001 -> flag=0 next edge; next inc accepted.
//  3 MODE 1, sync=0, after reset:
//    - flag=1; inc -> accept=0.
//    - sync=6'b000011 (bin 2) -> flag=0; two pops; flag=1 after the 2nd edge.
//  4 Wrap: 64 accepts with remote tracking -> ptr_bin 63->0; gray_ptr 6'b100000->0; addr sequence 0..31 twice.
//  5 Reset mid-operation: rst_n low for 1 ns between edges at ptr=17 -> all outputs at reset values at once, with no clk edge.
//  6 GRAY_PTR_LEVEL_EN, MODE 0, margin 4: 28 pushes -> level=28, almost=1; at 27 -> almost=0; undefined build -> level=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared gray-code helpers and side-selection constants for the async-FIFO pointer controllers.
package gray_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;

    // Helpers work on a fixed maximum width. Narrower pointers are zero-extended on the way in,
    // which does not change the code, and truncated on the way out.
    localparam int GRAY_MAX_W = 32;
    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational XOR-prefix gray-to-binary decoder for a W-bit pointer.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(gray_word_t'(gray)));

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an async-FIFO pointer pair: MODE 0 drives full, MODE 1 drives empty.
// Define GRAY_PTR_LEVEL_EN to build the level/almost outputs; otherwise they are tied off.
module gray_ptr_ctrl
    import gray_pkg::*;
#(
    parameter int ADDR_WIDTH    = 5,
    parameter int MODE          = MODE_WR,
    parameter int ALMOST_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   sync_gray_ptr,
    output logic                  accept,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   gray_ptr,
    output logic                  flag,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost
);

    localparam int   PW       = ADDR_WIDTH + 1;
    localparam logic FLAG_RST = (MODE == MODE_RD);

    logic [PW-1:0] ptr_bin;
    logic [PW-1:0] bin_nxt;
    logic [PW-1:0] gray_nxt;
    logic [PW-1:0] flag_ref;
    logic          flag_nxt;

    assign accept   = inc & ~flag;
    assign bin_nxt  = ptr_bin + PW'(accept);
    assign gray_nxt = PW'(bin2gray(gray_word_t'(bin_nxt)));
    assign addr     = ptr_bin[ADDR_WIDTH-1:0];

    generate
        if (MODE == MODE_WR) begin : g_full
            // Full when the write pointer is exactly one lap ahead: the two gray MSBs differ.
            assign flag_ref = {~sync_gray_ptr[ADDR_WIDTH -: 2], sync_gray_ptr[ADDR_WIDTH-2:0]};
        end else begin : g_empty
            assign flag_ref = sync_gray_ptr;
        end
    endgenerate

    // NOTE: the flag compares the next-state gray value, so it asserts on the same edge as the
    // accept that fills or drains the FIFO and no second request can slip through.
    assign flag_nxt = (gray_nxt == flag_ref);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_bin  <= '0;
            gray_ptr <= '0;
            flag     <= FLAG_RST;
        end else begin
            ptr_bin  <= bin_nxt;
            gray_ptr <= gray_nxt;
            flag     <= flag_nxt;
        end
    end

`ifdef GRAY_PTR_LEVEL_EN
    localparam logic [PW-1:0] ALMOST_FULL_TH  = PW'((1 << ADDR_WIDTH) - ALMOST_MARGIN);
    localparam logic [PW-1:0] ALMOST_EMPTY_TH = PW'(ALMOST_MARGIN);

    logic [PW-1:0] rbin;
    logic [PW-1:0] level_nxt;
    logic          almost_nxt;

    gray_to_bin #(.W(PW)) u_gray_to_bin (
        .gray (sync_gray_ptr),
        .bin  (rbin)
    );

    // Occupancy seen from this side; the remote view may lag, which only makes it pessimistic.
    assign level_nxt  = (MODE == MODE_WR) ? (bin_nxt - rbin) : (rbin - bin_nxt);
    assign almost_nxt = (MODE == MODE_WR) ? (level_nxt >= ALMOST_FULL_TH)
                                          : (level_nxt <= ALMOST_EMPTY_TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= '0;
            almost <= FLAG_RST;
        end else begin
            level  <= level_nxt;
            almost <= almost_nxt;
        end
    end
`else
    assign level  = '0;
    assign almost = FLAG_RST;
`endif

endmodule
